// File: rtl/rnn_mem_responder.sv
// Far-side memory/input-stream responder for the RNN accelerator: weight/bias/T tables,
// output H capture, 32-bit input vector stream and the ready/busy run sequencer.
module rnn_mem_responder #(
  parameter int OUT_DEPTH = 4096,
  parameter int X_DEPTH   = 64,
  parameter int W         = 20
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          ready,
  input  logic          busy,
  input  logic          i_en,
  output logic [31:0]   idata,
  input  logic          mce,
  input  logic [2:0]    msel,
  input  logic [16:0]   maddr,
  input  logic [W-1:0]  mdata_w,
  output logic [W-1:0]  mdata_r,
  input  logic          ld_en,
  input  logic [2:0]    ld_sel,
  input  logic [16:0]   ld_addr,
  input  logic [31:0]   ld_data,
  input  logic [16:0]   dump_addr,
  output logic [W-1:0]  dump_data,
  output logic          done,
  output logic [16:0]   wr_count,
  output logic          err_oob
);
  localparam int HW  = $clog2(OUT_DEPTH);
  localparam int XW  = $clog2(X_DEPTH);
  localparam int XPW = $clog2(X_DEPTH + 1);

  typedef enum logic [2:0] {IDLE, REQ, WAIT_BUSY, RUN, DONE} state_t;

  logic [W-1:0]  w_ih [2048];
  logic [W-1:0]  b_ih [64];
  logic [W-1:0]  w_hh [4096];
  logic [W-1:0]  b_hh [64];
  logic [W-1:0]  t_len;
  logic [W-1:0]  h_mem [OUT_DEPTH];
  logic [31:0]   x_mem [X_DEPTH];

  state_t         state;
  logic [2:0]     wait_cnt;
  logic [XPW-1:0] xptr;
  logic           rd_oob;
  logic           h_wr;
  logic           h_oob;
  logic           ld_bad;

  // Zero-latency read port; 110/111 with mce count as an illegal access.
  always_comb begin
    mdata_r = '0;
    rd_oob  = 1'b0;
    if (mce) begin
      case (msel)
        3'b000: if (maddr[16:11] == '0) mdata_r = w_ih[maddr[10:0]]; else rd_oob = 1'b1;
        3'b001: if (maddr[16:6] == '0)  mdata_r = b_ih[maddr[5:0]];  else rd_oob = 1'b1;
        3'b010: if (maddr[16:12] == '0) mdata_r = w_hh[maddr[11:0]]; else rd_oob = 1'b1;
        3'b011: if (maddr[16:6] == '0)  mdata_r = b_hh[maddr[5:0]];  else rd_oob = 1'b1;
        3'b100: if (maddr == '0)        mdata_r = t_len;             else rd_oob = 1'b1;
        3'b101: rd_oob = 1'b0;
        default: rd_oob = 1'b1;
      endcase
    end
  end

  always_comb begin
    h_wr  = mce && (msel == 3'b101) && (32'(maddr) < OUT_DEPTH);
    h_oob = mce && (msel == 3'b101) && (32'(maddr) >= OUT_DEPTH);
    ld_bad = 1'b0;
    if (ld_en) begin
      case (ld_sel)
        3'b000:        ld_bad = (ld_addr[16:11] != '0);
        3'b001, 3'b011: ld_bad = (ld_addr[16:6] != '0);
        3'b010:        ld_bad = (ld_addr[16:12] != '0);
        3'b100:        ld_bad = (ld_addr != '0);
        3'b101:        ld_bad = (32'(ld_addr) >= OUT_DEPTH);
        3'b110:        ld_bad = (32'(ld_addr) >= X_DEPTH);
        default:       ld_bad = 1'b1;
      endcase
    end
  end

  assign idata     = (32'(xptr) < X_DEPTH) ? x_mem[xptr[XW-1:0]] : 32'd0;
  assign dump_data = (32'(dump_addr) < OUT_DEPTH) ? h_mem[dump_addr[HW-1:0]] : '0;

  // Table storage; the accelerator H write is issued last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (ld_en && !ld_bad) begin
      case (ld_sel)
        3'b000:  w_ih[ld_addr[10:0]] <= ld_data[W-1:0];
        3'b001:  b_ih[ld_addr[5:0]]  <= ld_data[W-1:0];
        3'b010:  w_hh[ld_addr[11:0]] <= ld_data[W-1:0];
        3'b011:  b_hh[ld_addr[5:0]]  <= ld_data[W-1:0];
        3'b100:  t_len               <= ld_data[W-1:0];
        3'b101:  h_mem[ld_addr[HW-1:0]] <= ld_data[W-1:0];
        3'b110:  x_mem[ld_addr[XW-1:0]] <= ld_data;
        default: ;
      endcase
    end
    if (h_wr) h_mem[maddr[HW-1:0]] <= mdata_w;
  end

  // Run sequencer and counters; launch clears placed after the increments so they take priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ready    <= 1'b0;
      done     <= 1'b0;
      xptr     <= '0;
      wr_count <= '0;
      err_oob  <= 1'b0;
      wait_cnt <= '0;
    end else begin
      if (i_en && (32'(xptr) < X_DEPTH)) begin
        xptr <= xptr + XPW'(1);
        if (32'(xptr) + 1 == X_DEPTH) err_oob <= 1'b1;
      end
      if (h_wr && (wr_count != '1)) wr_count <= wr_count + 17'd1;
      if ((mce && rd_oob) || h_oob || ld_bad) err_oob <= 1'b1;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= REQ;
            ready    <= 1'b1;
            done     <= 1'b0;
            xptr     <= '0;
            wr_count <= '0;
          end
        end
        REQ: begin
          ready    <= 1'b0;
          wait_cnt <= '0;
          state    <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (busy) begin
            state <= RUN;
          end else if (wait_cnt == 3'd7) begin
            err_oob <= 1'b1;
            state   <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 3'd1;
          end
        end
        RUN: begin
          if (!busy) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rnn_mem_responder.sv
// Directed bench for rnn_mem_responder: table reads, run handshake, input stream,
// H writes with collision, wait-for-busy timeout and reset mid-run.
module tb_rnn_mem_responder;
  localparam int OUT_DEPTH = 4096;
  localparam int X_DEPTH   = 64;
  localparam int W         = 20;

  logic          clk = 1'b0;
  logic          reset, start, busy, i_en, mce, ld_en;
  logic          ready, done, err_oob;
  logic [2:0]    msel, ld_sel;
  logic [16:0]   maddr, ld_addr, dump_addr, wr_count;
  logic [W-1:0]  mdata_w, mdata_r, dump_data;
  logic [31:0]   ld_data, idata;

  int n_checks = 0;
  int n_fail   = 0;

  rnn_mem_responder #(.OUT_DEPTH(OUT_DEPTH), .X_DEPTH(X_DEPTH), .W(W)) dut (
    .clk(clk), .reset(reset), .start(start), .ready(ready), .busy(busy),
    .i_en(i_en), .idata(idata), .mce(mce), .msel(msel), .maddr(maddr),
    .mdata_w(mdata_w), .mdata_r(mdata_r), .ld_en(ld_en), .ld_sel(ld_sel),
    .ld_addr(ld_addr), .ld_data(ld_data), .dump_addr(dump_addr),
    .dump_data(dump_data), .done(done), .wr_count(wr_count), .err_oob(err_oob)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [2:0] sel, input logic [16:0] addr, input logic [31:0] data);
    ld_en = 1'b1; ld_sel = sel; ld_addr = addr; ld_data = data;
    tick();
    ld_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; busy = 1'b0; i_en = 1'b0; mce = 1'b0; ld_en = 1'b0;
    msel = '0; ld_sel = '0; maddr = '0; ld_addr = '0; dump_addr = '0;
    mdata_w = '0; ld_data = '0;
    tick(); tick();
    check("rst_ready", 32'(ready), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err_oob), 0);
    check("rst_wrcnt", 32'(wr_count), 0);
    reset = 1'b0;

    // Table preload and zero-latency reads
    load(3'b000, 17'h67, 32'h0ABCD);
    load(3'b010, 17'h123, 32'h55555);
    load(3'b001, 17'd63, 32'h01234);
    load(3'b100, 17'd0, 32'd2);
    mce = 1'b1; msel = 3'b000; maddr = 17'h67; #1;
    check("wih_read", 32'(mdata_r), 32'h0ABCD);
    msel = 3'b001; maddr = 17'd63; #1;
    check("bih_read", 32'(mdata_r), 32'h01234);
    msel = 3'b100; maddr = 17'd0; #1;
    check("t_read", 32'(mdata_r), 32'd2);
    msel = 3'b000; maddr = 17'h67; mce = 1'b0; #1;
    check("mce_off", 32'(mdata_r), 0);
    tick();
    check("no_err_after_reads", 32'(err_oob), 0);

    // Run handshake
    start = 1'b1; tick(); start = 1'b0;
    check("ready_pulse", 32'(ready), 1);
    tick();
    check("ready_drop", 32'(ready), 0);
    busy = 1'b1; tick(); tick();
    check("run_not_done", 32'(done), 0);
    busy = 1'b0; tick();
    check("done_set", 32'(done), 1);
    tick();
    check("done_held", 32'(done), 1);

    // Input stream
    load(3'b110, 17'd0, 32'hDEADBEEF);
    load(3'b110, 17'd1, 32'h12345678);
    check("idata_x0", idata, 32'hDEADBEEF);
    i_en = 1'b1; tick(); i_en = 1'b0;
    check("idata_x1", idata, 32'h12345678);
    check("no_err_stream", 32'(err_oob), 0);
    i_en = 1'b1;
    for (int i = 0; i < X_DEPTH; i++) tick();
    i_en = 1'b0;
    check("idata_sat", idata, 0);
    check("err_stream_sat", 32'(err_oob), 1);

    // Output H writes
    reset = 1'b1; tick(); reset = 1'b0;
    check("err_cleared", 32'(err_oob), 0);
    mce = 1'b1; msel = 3'b101; maddr = 17'h41; mdata_w = 20'hF0000; #1;
    check("h_read_zero", 32'(mdata_r), 0);
    tick(); mce = 1'b0;
    dump_addr = 17'h41; #1;
    check("h_dump_41", 32'(dump_data), 32'hF0000);
    check("wrcnt_1", 32'(wr_count), 1);
    check("no_err_hwrite", 32'(err_oob), 0);
    mce = 1'b1; maddr = 17'(OUT_DEPTH); mdata_w = 20'h77777; tick(); mce = 1'b0;
    check("h_oob_err", 32'(err_oob), 1);
    check("h_oob_wrcnt", 32'(wr_count), 1);
    #1;
    check("h_dump_41_kept", 32'(dump_data), 32'hF0000);

    // Same-cycle side-band and accelerator write to H[5]
    mce = 1'b1; msel = 3'b101; maddr = 17'd5; mdata_w = 20'h22222;
    ld_en = 1'b1; ld_sel = 3'b101; ld_addr = 17'd5; ld_data = 32'h11111;
    tick(); mce = 1'b0; ld_en = 1'b0;
    dump_addr = 17'd5; #1;
    check("h_collision", 32'(dump_data), 32'h22222);
    check("wrcnt_2", 32'(wr_count), 2);
    load(3'b101, 17'd6, 32'h33333);
    dump_addr = 17'd6; #1;
    check("h_sideband", 32'(dump_data), 32'h33333);

    // Wait-for-busy timeout
    reset = 1'b1; tick(); reset = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    check("to_ready", 32'(ready), 1);
    for (int i = 0; i < 8; i++) tick();
    check("to_not_yet", 32'(err_oob), 0);
    tick();
    check("to_err", 32'(err_oob), 1);
    start = 1'b1; tick(); start = 1'b0;
    check("to_back_idle", 32'(ready), 1);

    // Reset during RUN
    tick();
    busy = 1'b1; tick(); tick();
    reset = 1'b1; tick(); reset = 1'b0; busy = 1'b0;
    check("rr_ready", 32'(ready), 0);
    check("rr_done", 32'(done), 0);
    tick(); tick();
    check("rr_no_done", 32'(done), 0);
    mce = 1'b1; msel = 3'b010; maddr = 17'h123; #1;
    check("whh_intact", 32'(mdata_r), 32'h55555);
    check("whh_no_err", 32'(err_oob), 0);

    // Out-of-range reads
    msel = 3'b001; maddr = 17'd64; #1;
    check("oob_read_zero", 32'(mdata_r), 0);
    tick(); mce = 1'b0;
    check("oob_read_err", 32'(err_oob), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/rnn_mem_responder.md
Name: rnn_mem_responder

Overview:
Memory and input-stream responder that sits on the far side of the RNN accelerator's memory/input interface. It serves weight, bias and sequence-length reads selected by msel/maddr, and accepts output hidden-state writes. It also feeds 32-bit input vectors on i_en and sequences a run with ready/busy. A side-band load/dump port lets the testbench or host preload tables and read back results.

Parameters:
OUT_DEPTH, 4096, entries in output H region (msel 101); must be ≤ 2^17
X_DEPTH, 64, entries in 32-bit input vector region
W, 20, memory data width

Ports:
clk  in  1  clock
reset  in  1  synchronous reset, active-high
start  in  1  one-cycle request to launch a run
ready  out  1  one-cycle run request to accelerator
busy  in  1  accelerator busy
i_en  in  1  accelerator requests next input vector
idata  out  32  current input vector
mce  in  1  memory access enable
msel  in  3  region select
maddr  in  17  region address
mdata_w  in  20  write data (msel 101)
mdata_r  out  20  read data
ld_en  in  1  side-band write strobe
ld_sel  in  3  side-band region (000-101 as msel; 110 = X region)
ld_addr  in  17  side-band address
ld_data  in  32  side-band data (low 20 bits for non-X regions)
dump_addr  in  17  output-region readback address
dump_data  out  20  H[dump_addr], combinational
done  out  1  run complete, held until next start
wr_count  out  17  output words written this run
err_oob  out  1  sticky out-of-range or illegal access

Behaviour:
- Regions: 000 W_ih 2048 entries (addr {h[5:0],i[4:0]}); 001 b_ih 64; 010 W_hh 4096 (addr {h,j}); 011 b_hh 64; 100 T, 1 entry at addr 0; 101 H, OUT_DEPTH entries, write-only from accelerator; 110/111 unused.
- Read: zero-cycle latency. mdata_r is combinational from the current msel/maddr and array contents. Value is valid in the same cycle the address is presented, so the accelerator samples it at the next edge.
- mdata_r = 0 when mce=0, when msel is 101/110/111, or when the address is out of range. An out-of-range address with mce=1 sets err_oob (msel 101 excluded, since it is a write region).
- Write: at posedge with mce=1 and msel=101:
  - addr < OUT_DEPTH: H[maddr] <= mdata_w and wr_count++ (saturating at 2^17-1).
  - addr ≥ OUT_DEPTH: write dropped and err_oob set.
- Input stream: idata = X[xptr] combinational (0 if xptr ≥ X_DEPTH). xptr increments at each posedge with i_en=1, saturating at X_DEPTH; reaching saturation sets err_oob. xptr is cleared on start.
- Side-band: ld_en writes at posedge to the selected region, including T and H. ld_sel 111 or an out-of-range address is ignored and sets err_oob. If ld_en and an accelerator write target the same H address in the same cycle, the accelerator write wins.
- FSM states: IDLE, REQ, WAIT_BUSY, RUN, DONE.
  - IDLE: start -> REQ. Clears xptr, wr_count and done.
  - REQ: ready=1 for exactly one cycle, then WAIT_BUSY.
  - WAIT_BUSY: busy=1 -> RUN. After 8 cycles without busy, set err_oob and go to IDLE.
  - RUN: busy falls to 0 -> DONE.
  - DONE: done=1. start -> REQ, and the clears apply.
  - start is ignored in REQ, WAIT_BUSY and RUN.
- Reset: FSM=IDLE, ready=0, done=0, xptr=0, wr_count=0, err_oob=0. Array contents are not cleared. Reset mid-run aborts to IDLE the next cycle.
- mdata_r, idata and dump_data have no reset value; they follow their arrays combinationally.

Test Plan:
- Preload W_ih[{6'd3,5'd7}]=20'h0ABCD, then drive mce=1, msel=000, maddr=0x67 -> mdata_r=0x0ABCD in the same cycle. Drive mce=0 -> mdata_r=0.
- Preload T=2. Pulse start -> ready high exactly 1 cycle, 1 cycle after start. Raise busy 1 cycle later -> RUN. Drop busy -> done=1 the next cycle.
- Preload X[0]=0xDEADBEEF and X[1]=0x12345678. Pulse i_en once -> idata changes from 0xDEADBEEF to 0x12345678 after the edge. Then X_DEPTH i_en pulses -> idata=0 and err_oob=1.
- Write msel=101, maddr=0x0041, mdata_w=0xF0000 -> dump_data at 0x41 = 0xF0000 and wr_count=1. Write maddr=OUT_DEPTH -> no write, err_oob=1, wr_count unchanged.
- Same-cycle ld_en(sel 101, addr 5, 0x11111) and accelerator write(addr 5, 0x22222) -> H[5]=0x22222.
- Pulse start with busy held 0 -> err_oob=1 and FSM back in IDLE after 8 cycles. Assert reset during RUN -> ready=0, done=0, preloaded W_hh contents intact.
